// File: rtl/cci_host_responder.sv
// rtl/cci_host_responder.sv - CCI system-side responder: read queue, write pipe, backing line memory
// Optional feature macro: CCI_RSP_THROTTLE_EN (read dequeue limited to every other cycle).
module cci_host_responder #(
  parameter int TXHDR_WIDTH    = 61,
  parameter int RXHDR_WIDTH    = 18,
  parameter int CACHE_WIDTH    = 512,
  parameter int MEM_LINES_LOG2 = 10,
  parameter int RD_QUEUE_DEPTH = 32,
  parameter int READ_LATENCY   = 8,
  parameter int WRITE_LATENCY  = 4,
  parameter int INIT_DELAY     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [TXHDR_WIDTH-1:0] tx0_hdr,
  input  logic                   tx0_rdvalid,
  input  logic [TXHDR_WIDTH-1:0] tx1_hdr,
  input  logic [CACHE_WIDTH-1:0] tx1_data,
  input  logic                   tx1_wrvalid,
  input  logic                   tx1_irvalid,
  output logic [RXHDR_WIDTH-1:0] rx0_hdr,
  output logic [CACHE_WIDTH-1:0] rx0_data,
  output logic                   rx0_rdvalid,
  output logic                   rx0_wrvalid,
  output logic                   rx0_cfgvalid,
  output logic [RXHDR_WIDTH-1:0] rx1_hdr,
  output logic                   rx1_wrvalid,
  output logic                   tx0_almostfull,
  output logic                   tx1_almostfull,
  output logic                   lp_initdone,
  output logic                   err_overflow
);
  localparam int AW = MEM_LINES_LOG2;
  localparam int QW = $clog2(RD_QUEUE_DEPTH);
  localparam int IW = $clog2(INIT_DELAY + 1);
  localparam logic [15:0] AGE_MIN  = 16'(READ_LATENCY - 1);
  localparam logic [QW:0] AF_LEVEL = (QW+1)'(RD_QUEUE_DEPTH - 8);
  localparam logic [QW:0] Q_FULL   = (QW+1)'(RD_QUEUE_DEPTH);

  logic [CACHE_WIDTH-1:0] mem [2**AW];
  logic [AW-1:0]          q_addr  [RD_QUEUE_DEPTH];
  logic [13:0]            q_mdata [RD_QUEUE_DEPTH];
  logic [15:0]            q_stamp [RD_QUEUE_DEPTH];
  logic [QW-1:0]          wr_ptr, rd_ptr;
  logic [QW:0]            q_count, q_count_nxt;
  logic [15:0]            now, head_age;
  logic                   q_empty, q_full, pop, push_ok;
  logic                   rd_vld_q;
  logic [13:0]            rd_mdata_q;
  logic [CACHE_WIDTH-1:0] rd_line;
  logic [WRITE_LATENCY-1:0] wp_vld;
  logic [13:0]            wp_md [WRITE_LATENCY];
  logic [IW-1:0]          init_cnt;
  logic [AW-1:0]          rd_addr, wr_addr;
  logic                   unused_hdr_bits;
`ifdef CCI_RSP_THROTTLE_EN
  logic                   thr_q;
`endif

  assign rd_addr      = tx0_hdr[14 +: AW];
  assign wr_addr      = tx1_hdr[14 +: AW];
  assign rx0_wrvalid  = 1'b0;
  assign rx0_cfgvalid = 1'b0;
  assign unused_hdr_bits = ^{tx0_hdr[TXHDR_WIDTH-1:14+AW], tx1_hdr[TXHDR_WIDTH-1:14+AW], tx1_irvalid};

  // Age uses modulo-2^16 subtraction so the stamp wrap is transparent.
  always_comb begin
    q_empty  = (q_count == '0);
    q_full   = (q_count == Q_FULL);
    head_age = now - q_stamp[rd_ptr];
    pop      = !q_empty && (head_age >= AGE_MIN);
`ifdef CCI_RSP_THROTTLE_EN
    pop      = pop && !thr_q;
`endif
    push_ok     = tx0_rdvalid && (!q_full || pop);
    q_count_nxt = q_count + (QW+1)'(push_ok) - (QW+1)'(pop);
  end

  // Storage is never reset; read-before-write hides a write on the dequeue edge.
  always_ff @(posedge clk) begin
    if (tx1_wrvalid) mem[wr_addr] <= tx1_data;
    if (push_ok) begin
      q_addr[wr_ptr]  <= rd_addr;
      q_mdata[wr_ptr] <= tx0_hdr[13:0];
      q_stamp[wr_ptr] <= now;
    end
    if (pop) begin
      rd_line    <= mem[q_addr[rd_ptr]];
      rd_mdata_q <= q_mdata[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      now            <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      q_count        <= '0;
      rd_vld_q       <= 1'b0;
      rx0_rdvalid    <= 1'b0;
      rx0_hdr        <= '0;
      rx0_data       <= '0;
      wp_vld         <= '0;
      for (int i = 0; i < WRITE_LATENCY; i++) wp_md[i] <= '0;
      rx1_wrvalid    <= 1'b0;
      rx1_hdr        <= '0;
      tx0_almostfull <= 1'b0;
      tx1_almostfull <= 1'b0;
      init_cnt       <= '0;
      lp_initdone    <= 1'b0;
      err_overflow   <= 1'b0;
`ifdef CCI_RSP_THROTTLE_EN
      thr_q          <= 1'b0;
`endif
    end else begin
      now <= now + 16'd1;
      if (push_ok) wr_ptr <= wr_ptr + QW'(1);
      if (pop) rd_ptr <= rd_ptr + QW'(1);
      q_count <= q_count_nxt;
      if (tx0_rdvalid && !push_ok) err_overflow <= 1'b1;
      tx0_almostfull <= (q_count_nxt >= AF_LEVEL);
`ifdef CCI_RSP_THROTTLE_EN
      thr_q <= pop;
`endif
      rd_vld_q    <= pop;
      rx0_rdvalid <= rd_vld_q;
      if (rd_vld_q) begin
        rx0_hdr  <= RXHDR_WIDTH'({4'h4, rd_mdata_q});
        rx0_data <= rd_line;
      end

      for (int i = WRITE_LATENCY - 1; i > 0; i--) begin
        wp_vld[i] <= wp_vld[i-1];
        wp_md[i]  <= wp_md[i-1];
      end
      wp_vld[0]      <= tx1_wrvalid;
      wp_md[0]       <= tx1_hdr[13:0];
      rx1_wrvalid    <= wp_vld[WRITE_LATENCY-1];
      if (wp_vld[WRITE_LATENCY-1]) rx1_hdr <= RXHDR_WIDTH'({4'h1, wp_md[WRITE_LATENCY-1]});
      tx1_almostfull <= &wp_vld;

      if (!lp_initdone) begin
        init_cnt <= init_cnt + IW'(1);
        if (init_cnt == IW'(INIT_DELAY - 1)) lp_initdone <= 1'b1;
      end
    end
  end
endmodule
